// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver running on the board clock with tick enables.
// Double-buffered display data swaps only at frame boundaries so a frame never tears.
module seg_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 131072,
  parameter int BLINK_SCANS = 64,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic                  busy,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW    = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(BLINK_SCANS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PW-1:0]       r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [FW-1:0]       r_frame;
  logic                r_phase;

  logic [4*DIGITS-1:0] r_pend_value, r_act_value;
  logic [DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [DIGITS-1:0]   r_pend_en, r_act_en;
  logic [DIGITS-1:0]   r_pend_blink, r_act_blink;
  logic                r_pend_lz, r_act_lz;
  logic                r_pend_flag;
  logic                r_frame_start;

  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic                r_dp;

  logic                w_tick;
  logic                w_boundary;
  logic [DIGITS-1:0]   w_upper_zero;
  logic [3:0]          w_nib;
  logic                w_en, w_bl, w_dp, w_lz_hit;
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  // Prescaler, scan index and blink timing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      if (w_boundary) begin
        if (r_frame == FRAME_LAST) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
    end
  end

  // Pending/active register sets; a load on a swap edge still lands in pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_value  <= '0;
      r_pend_dp     <= '0;
      r_pend_en     <= '0;
      r_pend_blink  <= '0;
      r_pend_lz     <= 1'b0;
      r_act_value   <= '0;
      r_act_dp      <= '0;
      r_act_en      <= '0;
      r_act_blink   <= '0;
      r_act_lz      <= 1'b0;
      r_pend_flag   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_boundary && r_pend_flag) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_en    <= r_pend_en;
        r_act_blink <= r_pend_blink;
        r_act_lz    <= r_pend_lz;
      end
      if (load) begin
        r_pend_value <= value;
        r_pend_dp    <= dp;
        r_pend_en    <= digit_en;
        r_pend_blink <= blink;
        r_pend_lz    <= lz_blank;
        r_pend_flag  <= 1'b1;
      end else if (w_boundary) begin
        r_pend_flag  <= 1'b0;
      end
      r_frame_start <= w_boundary && r_pend_flag;
    end
  end

  // w_upper_zero[k]: nibbles k..DIGITS-1 of the active value are all zero
  always_comb begin
    logic acc;
    acc = 1'b1;
    w_upper_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc = acc && (r_act_value[4*k +: 4] == 4'h0);
      w_upper_zero[k] = acc;
    end
  end

  always_comb begin
    w_nib    = 4'h0;
    w_en     = 1'b0;
    w_bl     = 1'b0;
    w_dp     = 1'b0;
    w_lz_hit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_act_value[4*k +: 4];
        w_en     = r_act_en[k];
        w_bl     = r_act_blink[k];
        w_dp     = r_act_dp[k];
        w_lz_hit = r_act_lz && (k != 0) && w_upper_zero[k];
      end
    end
  end

  assign w_blank  = !w_en || (w_bl && r_phase) || w_lz_hit;
  assign w_onehot = DIGITS'(1) << r_idx;

  // Output pattern register, updated only on tick edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an  <= '0;
      r_seg <= '0;
      r_dp  <= 1'b0;
    end else if (w_tick) begin
      r_an  <= w_blank ? '0 : w_onehot;
      r_seg <= w_blank ? 7'h00 : hex7(w_nib);
      r_dp  <= !w_blank && w_dp;
    end
  end

  assign an          = ACTIVE_LOW ? ~r_an  : r_an;
  assign seg         = ACTIVE_LOW ? ~r_seg : r_seg;
  assign dp_out      = ACTIVE_LOW ? ~r_dp  : r_dp;
  assign busy        = r_pend_flag;
  assign frame_start = r_frame_start;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment scan driver that replaces the fixed divided-clock display path on the board top. It runs entirely on the board clock, using clock-enable ticks instead of derived clocks. It scans `DIGITS` hex digits and adds per-digit enable, blink, decimal point and leading-zero suppression. New values load through a handshake that swaps them in only at frame boundaries, so the display never tears. It sits between the CPU debug/status outputs and the `AN`/`CA` pins.

## Interface

Parameters:
- `DIGITS`, 8: number of digits scanned, range 1..8.
- `SCAN_DIV`, 131072: board-clock cycles per digit slot, minimum 2.
- `BLINK_SCANS`, 64: full frames per blink half-period, minimum 1.
- `ACTIVE_LOW`, 1: when 1, `an`, `seg` and `dp_out` are active-low; when 0, they are active-high.

Ports:
- `clock` in 1: board clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `value` in 4*DIGITS: hex nibbles; nibble k (`value[4k+3:4k]`) drives digit k; digit 0 is rightmost.
- `dp` in DIGITS: decimal point per digit.
- `digit_en` in DIGITS: per-digit enable; 0 blanks the digit.
- `blink` in DIGITS: per-digit blink enable.
- `lz_blank` in 1: leading-zero suppression enable.
- `load` in 1: one-cycle (or held) request to capture all inputs above.
- `busy` out 1: a captured value is pending and not yet displayed.
- `an` out DIGITS: digit anodes, one-hot active.
- `seg` out 7: segments, {g,f,e,d,c,b,a}.
- `dp_out` out 1: decimal point segment.
- `frame_start` out 1: one-cycle pulse when new display data becomes active.

## Operation

- **Prescaler:** counts 0..SCAN_DIV-1 and wraps. `tick` is high in the cycle where the count equals SCAN_DIV-1.
- **Scan index:** runs 0..DIGITS-1. On each tick, the outputs register the pattern for the current index, then the index increments and wraps to 0 after DIGITS-1.
- **Frame boundary:** a tick with index = DIGITS-1.
- **Register sets:** two sets, `pending` and `active`, each holding `value`, `dp`, `digit_en`, `blink` and `lz_blank`.
- **Load:**
  - When `load` is high, the inputs are copied into `pending` and the pending flag is set.
  - A load while the flag is already set overwrites `pending`; the latest value wins.
  - `busy` is the pending flag, registered.
- **Swap at frame boundary:** if the pending flag is set, `active` takes `pending`, the flag clears, and `frame_start` pulses the following cycle.
- **Load coinciding with a frame boundary:**
  - If the flag is already set, the old pending set transfers to `active`, the new inputs enter `pending`, and the flag stays set.
  - If the flag is clear, the inputs are captured into `pending` and transfer at the next boundary.
- **Blanking:** digit k is blanked (anode inactive, segments and dp off) if any of these holds:
  - `digit_en[k]` = 0;
  - `blink[k]` = 1 and blink phase = 1;
  - `lz_blank` = 1, k ≠ 0, and nibbles k..DIGITS-1 are all zero.
- **Blink:** a frame counter runs 0..BLINK_SCANS-1 and increments at each frame boundary. The blink phase toggles on wrap. Phase 0 means visible.
- **Hex encoding (active-high, before polarity):** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Polarity:** with ACTIVE_LOW = 1, `an`, `seg` and `dp_out` are bitwise inverted.
- **Ghosting:** exactly one anode is active at a time, or none when the digit is blanked.

## Timing

- **Reset values (asserted asynchronously):**
  - `an`, `seg` and `dp_out` inactive (all ones when ACTIVE_LOW = 1).
  - `busy` = 0, `frame_start` = 0.
  - Prescaler, index, frame counter and blink phase = 0.
  - `active` and `pending` cleared, so `digit_en` = 0 and the display is blank.
- **First tick:** occurs on the SCAN_DIV-th rising edge after `reset` deasserts.
- **Output latency:** `an`, `seg` and `dp_out` change only on tick edges and are registered, with no combinational path from inputs.
- **Busy latency:** `busy` rises on the edge that samples `load`.
- **Swap edge:** `busy` falls, and `active` updates, on the frame-boundary edge. `frame_start` is high for the one cycle after that edge.
- **First display of new data:** digit 0 of new data appears at the first tick after the swap. Worst-case load-to-display latency is (DIGITS+1)·SCAN_DIV cycles.
- **Reset mid-operation:** the pending value is discarded, the display blanks, and scanning restarts from index 0.

## Test plan

Bench parameters: DIGITS = 4, SCAN_DIV = 4, BLINK_SCANS = 2, ACTIVE_LOW = 1.

1. **Reset:** hold `reset` low, then release. Required: an = F, seg = 7F, dp_out = 1 and busy = 0 throughout; first tick on the 4th edge after release; outputs stay blank.
2. **Load:** pulse `load` with value = 12A4, digit_en = F, dp = 0. Required: busy = 1 until the next boundary; one `frame_start` pulse. Then the slots show:
   - an = E with seg = 19 (digit "4");
   - an = D with seg = 08 ("A");
   - an = B with seg = 24 ("2");
   - an = 7 with seg = 79 ("1").
3. **Leading-zero suppression:** value = 0030 with lz_blank = 1. Required: the digit 3 and digit 2 slots have an = F; digit 1 shows seg = 30; digit 0 shows seg = 40.
4. **Blink:** blink = 1 with digit_en = F. Required: digit 0 is visible for 2 frames, then an = F in its slot for 2 frames, repeating; digits 1–3 are unaffected.
5. **Back-to-back loads:** two loads in one frame (1111, then 2222). Required: a single `frame_start` pulse; 2222 is displayed; 1111 never appears.
6. **Reset mid-load:** assert `reset` while busy = 1. Required: outputs go inactive immediately, busy = 0, and the pending value is never displayed after release.
